// File: rtl/divclk_select.sv
// -----------------------------------------------------------------------------
// divclk_select
//
// Glitch-free selector placed after the power-of-two clock divider. One of the
// divider's registered taps is forwarded to clk_out through a single flop.
// Tap changes are requested with a valid/ready handshake. The output is never
// cut during a high phase. It is held low for at least one cycle before the
// new tap starts on a clean rising edge.
//
// Handshake: a request is accepted on any cycle where sel_valid && sel_ready.
// sel_ready is high only in RUN. Requests are not queued, so the requester
// holds sel_valid and sel stable until it sees ready. The sel value present
// on the accepting cycle is the one that takes effect.
//
// Ports:
//   clk         system clock, same clock that drives the divider
//   rst_n       asynchronous active-low reset
//   taps        divided clocks, taps[i] = clk / 2**(i+1), registered in clk
//   sel         requested tap index
//   sel_valid   request strobe for sel
//   sel_ready   high when a request can be accepted (state == RUN)
//   clk_out     selected divided clock, registered
//   active_sel  tap index currently driving (or about to drive) clk_out
//   busy        high while a switch is in progress (state != RUN)
//   sel_err     one-cycle pulse after an accepted out-of-range request
//   switch_cnt  number of completed switches, wraps silently
// -----------------------------------------------------------------------------
module divclk_select #(
    parameter int NUM_TAPS = 10,
    parameter int SEL_W    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_TAPS-1:0] taps,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_valid,
    output logic                sel_ready,
    output logic                clk_out,
    output logic [SEL_W-1:0]    active_sel,
    output logic                busy,
    output logic                sel_err,
    output logic [CNT_W-1:0]    switch_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ARM   = 2'd2
    } state_t;

    // One bit wider than sel so the range check also works when
    // NUM_TAPS == 2**SEL_W.
    localparam logic [SEL_W:0] NUM_TAPS_EXT = (SEL_W+1)'(NUM_TAPS);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   active_sel_q, active_sel_d;
    logic [SEL_W-1:0]   pending_q, pending_d;
    logic               clk_out_q, clk_out_d;
    logic               sel_err_q, sel_err_d;
    logic [CNT_W-1:0]   switch_cnt_q, switch_cnt_d;
    // Set by reset so that the ARM exit after reset is not counted as a switch.
    logic               first_arm_q, first_arm_d;

    logic               tap_cur;
    logic               accept;
    logic               sel_oob;
    logic               switch_req;

    // Current tap value. An explicit compare loop avoids an indexed select
    // whose index range exceeds the tap bus.
    always_comb begin
        tap_cur = 1'b0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (active_sel_q == SEL_W'(i)) begin
                tap_cur = taps[i];
            end
        end
    end

    assign accept     = sel_valid && (state_q == ST_RUN);
    assign sel_oob    = ({1'b0, sel} >= NUM_TAPS_EXT);
    assign switch_req = accept && !sel_oob && (sel != active_sel_q);

    // -------------------------------------------------------------------------
    // State register (and the datapath flops that share its reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARM;
            active_sel_q <= '0;
            pending_q    <= '0;
            clk_out_q    <= 1'b0;
            sel_err_q    <= 1'b0;
            switch_cnt_q <= '0;
            first_arm_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            pending_q    <= pending_d;
            clk_out_q    <= clk_out_d;
            sel_err_q    <= sel_err_d;
            switch_cnt_q <= switch_cnt_d;
            first_arm_q  <= first_arm_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (switch_req) begin
                    state_d = ST_DRAIN;
                end
            end
            // Leave DRAIN only once the old tap is low, so its high phase is
            // never truncated.
            ST_DRAIN: begin
                if (!tap_cur) begin
                    state_d = ST_ARM;
                end
            end
            // In ARM, tap_cur already refers to the new tap. Waiting for it to
            // be low guarantees the first output edge in RUN is a full rise.
            ST_ARM: begin
                if (!tap_cur) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        active_sel_d = active_sel_q;
        pending_d    = pending_q;
        clk_out_d    = tap_cur;
        sel_err_d    = 1'b0;
        switch_cnt_d = switch_cnt_q;
        first_arm_d  = first_arm_q;
        case (state_q)
            ST_RUN: begin
                if (accept && sel_oob) begin
                    sel_err_d = 1'b1;
                end
                if (switch_req) begin
                    pending_d = sel;
                end
            end
            ST_DRAIN: begin
                if (!tap_cur) begin
                    active_sel_d = pending_q;
                end
            end
            ST_ARM: begin
                clk_out_d = 1'b0;
                if (!tap_cur) begin
                    if (first_arm_q) begin
                        first_arm_d = 1'b0;
                    end else begin
                        switch_cnt_d = switch_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                clk_out_d = 1'b0;
            end
        endcase
    end

    assign sel_ready  = (state_q == ST_RUN);
    assign busy       = (state_q != ST_RUN);
    assign clk_out    = clk_out_q;
    assign active_sel = active_sel_q;
    assign sel_err    = sel_err_q;
    assign switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_divclk_select.sv
// -----------------------------------------------------------------------------
// tb_divclk_select
//
// The divider is modelled as a free-running counter. The counter value sampled
// at a clk edge is used as that edge's index, so tap i at edge k is bit i of k.
// The reference model is event based. When a switch is accepted, it computes
// two edges from counter arithmetic:
//   drain_end = first edge after acceptance where the old tap samples low
//   arm_end   = first edge after drain_end where the new tap samples low
// The expected waveform after edge k follows from those two numbers:
//   k <= drain_end            : old tap bit of k
//   drain_end < k <= arm_end  : low
//   otherwise                 : current tap bit of k
// -----------------------------------------------------------------------------
module tb_divclk_select;

    localparam int NUM_TAPS = 10;
    localparam int SEL_W    = 4;
    localparam int CNT_W    = 8;

    logic                clk;
    logic                rst_n;
    logic [NUM_TAPS-1:0] taps;
    logic [SEL_W-1:0]    sel;
    logic                sel_valid;
    logic                sel_ready;
    logic                clk_out;
    logic [SEL_W-1:0]    active_sel;
    logic                busy;
    logic                sel_err;
    logic [CNT_W-1:0]    switch_cnt;

    logic [31:0]         div_cnt;

    int n_vec = 0;
    int n_err = 0;

    // ---------------------------------------------------------------- clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial div_cnt = '0;
    always @(posedge clk) div_cnt <= div_cnt + 32'd1;
    assign taps = div_cnt[NUM_TAPS-1:0];

    divclk_select #(
        .NUM_TAPS(NUM_TAPS),
        .SEL_W   (SEL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .taps      (taps),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .clk_out   (clk_out),
        .active_sel(active_sel),
        .busy      (busy),
        .sel_err   (sel_err),
        .switch_cnt(switch_cnt)
    );

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic tbit(input int v, input int b);
        return 1'((v >> b) & 1);
    endfunction

    function automatic int first_low(input int from, input int b);
        for (int j = from; j < from + 4096; j++) begin
            if (tbit(j, b) == 1'b0) return j;
        end
        return from;
    endfunction

    // ---------------------------------------------------------------- reference model
    int         cur_s     = 0;
    int         old_s     = 0;
    int         new_s     = 0;
    int         drain_end = 0;
    int         arm_end   = 0;
    int         err_edge  = -10;
    bit         sw        = 0;
    bit         need_arm  = 1;
    bit         rst_arm   = 0;
    logic [7:0] exp_cnt   = '0;

    always @(negedge clk) begin
        int   k;
        logic exp_co, exp_busy, exp_err, exp_rdy;
        int   exp_act;
        k = int'(div_cnt) - 1;
        if (!rst_n) begin
            need_arm = 1; sw = 0; rst_arm = 0; cur_s = 0; exp_cnt = '0; err_edge = -10;
            exp_co = 1'b0; exp_busy = 1'b1; exp_act = 0; exp_err = 1'b0;
        end else begin
            if (need_arm) begin
                // The first edge after reset release is k+1; ARM watches tap 0.
                need_arm = 0; sw = 1; rst_arm = 1; old_s = 0; new_s = 0;
                drain_end = k; arm_end = first_low(k + 1, 0);
            end
            exp_err = (k == err_edge);
            if (sw) begin
                if (k <= drain_end && !rst_arm) exp_co = tbit(k, old_s);
                else if (k <= arm_end)          exp_co = 1'b0;
                else                            exp_co = tbit(k, new_s);
                exp_busy = (k < arm_end);
                exp_act  = (k >= drain_end) ? new_s : old_s;
            end else begin
                exp_co = tbit(k, cur_s); exp_busy = 1'b0; exp_act = cur_s;
            end
            if (sw && k == arm_end) begin
                if (!rst_arm) exp_cnt = exp_cnt + 8'd1;
                cur_s = new_s; sw = 0; rst_arm = 0;
            end
        end
        exp_rdy = rst_n && !sw && !need_arm;
        check("clk_out",    32'(clk_out),    32'(exp_co));
        check("busy",       32'(busy),       32'(exp_busy));
        check("sel_ready",  32'(sel_ready),  32'(exp_rdy));
        check("active_sel", 32'(active_sel), 32'(exp_act));
        check("sel_err",    32'(sel_err),    32'(exp_err));
        check("switch_cnt", 32'(switch_cnt), 32'(exp_cnt));
        // A request sampled at edge k+1 is accepted if the model is in RUN.
        if (exp_rdy && sel_valid) begin
            if (int'(sel) >= NUM_TAPS) begin
                err_edge = k + 1;
            end else if (int'(sel) != cur_s) begin
                sw = 1; old_s = cur_s; new_s = int'(sel);
                drain_end = first_low(k + 2, old_s);
                arm_end   = first_low(drain_end + 1, new_s);
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // All tasks start and end at posedge + 1.
    task automatic send(input logic [SEL_W-1:0] s);
        int guard;
        guard = 0;
        sel = s; sel_valid = 1'b1;
        @(negedge clk);
        while (!sel_ready && guard < 5000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 5000) check("ready_timeout", 32'(sel_ready), 32'd1);
        @(posedge clk); #1;
        sel_valid = 1'b0;
        sel = SEL_W'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 5000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 5000) check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_tap_high(input int b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!(taps[b] && taps[4:0] < 5'd8) && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 3000) check("tap_timeout", 32'(taps[b]), 32'd1);
        @(posedge clk); #1;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [SEL_W-1:0] s;
        int guard;
        rst_n = 1'b0; sel = '0; sel_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle();
        check("reset_active", 32'(active_sel), 32'd0);
        check("reset_cnt",    32'(switch_cnt), 32'd0);

        // 0 -> 3
        send(4'd3);
        check("ready_low_after_accept", 32'(sel_ready), 32'd0);
        wait_idle();
        repeat (20) @(posedge clk);
        #1 check("sw03_active", 32'(active_sel), 32'd3);
        check("sw03_cnt", 32'(switch_cnt), 32'd1);

        // invalid, then same-tap request
        send(4'd12);
        check("err_pulse", 32'(sel_err), 32'd1);
        check("err_ready", 32'(sel_ready), 32'd1);
        @(posedge clk); #1 check("err_clear", 32'(sel_err), 32'd0);
        send(4'd3);
        check("same_ready", 32'(sel_ready), 32'd1);
        check("same_active", 32'(active_sel), 32'd3);

        // up to tap 9, then down-switch while tap 9 is high,
        // with a held, changing request during the long drain
        send(4'd9);
        wait_idle();
        wait_tap_high(9);
        send(4'd0);
        sel = 4'd5; sel_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("held_not_accepted", 32'(sel_ready), 32'd0);
        send(4'd7);
        wait_idle();
        check("held_takes_7", 32'(active_sel), 32'd7);

        // random requests
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) s = SEL_W'($urandom_range(10, 15));
            else                           s = SEL_W'($urandom_range(0, 5));
            send(s);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();

        // counter wrap
        guard = 0;
        while (exp_cnt != 8'd255 && guard < 600) begin
            guard++;
            send((cur_s == 0) ? 4'd1 : 4'd0);
            wait_idle();
        end
        check("cnt_at_255", 32'(switch_cnt), 32'd255);
        send((cur_s == 0) ? 4'd1 : 4'd0);
        wait_idle();
        check("cnt_wrap", 32'(switch_cnt), 32'd0);

        // async reset two cycles into a 0 -> 5 drain
        send(4'd0);
        wait_idle();
        wait_tap_high(5);
        send(4'd5);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_clk_out", 32'(clk_out),    32'd0);
        check("async_active",  32'(active_sel), 32'd0);
        check("async_busy",    32'(busy),       32'd1);
        check("async_cnt",     32'(switch_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle();
        check("restart_active", 32'(active_sel), 32'd0);
        repeat (10) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        check("global_timeout", 32'd0, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/divclk_select.md
Name: divclk_select

Overview:
- Glitch-free output selector that sits directly downstream of the power-of-two clock divider.
- Takes the divider's ten registered divided-clock taps (÷2 … ÷1024) and drives one of them onto a single clk_out.
- Changes to the selected tap are requested through a valid/ready handshake.
- A switch never produces a runt high or low phase shorter than one clk cycle, and never truncates a high phase.

Parameters:
- NUM_TAPS, 10, number of divided-clock taps on the input bus.
- SEL_W, 4, width of the tap-select field; must satisfy 2**SEL_W >= NUM_TAPS.
- CNT_W, 8, width of the completed-switch counter.

Ports:
- clk  input  1  system clock, same clock that drives the divider.
- rst_n  input  1  reset; asynchronous, active-low.
- taps  input  NUM_TAPS  divided clocks, registered in the clk domain; taps[i] = clk ÷ 2**(i+1), 50% duty.
- sel  input  SEL_W  requested tap index.
- sel_valid  input  1  request strobe for sel.
- sel_ready  output  1  high when a request can be accepted.
- clk_out  output  1  selected divided clock, registered.
- active_sel  output  SEL_W  tap index currently driving, or about to drive, clk_out.
- busy  output  1  high while a switch is in progress.
- sel_err  output  1  one-cycle pulse on an accepted out-of-range request.
- switch_cnt  output  CNT_W  number of completed switches; wraps.

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low on rst_n. All state is updated on posedge clk or negedge rst_n.
- Reset values: state=ARM, active_sel=0, pending=0, clk_out=0, sel_err=0, switch_cnt=0.
- Derived outputs: busy = (state != RUN); sel_ready = (state == RUN).
- Request acceptance: a request is accepted on a cycle where sel_valid && sel_ready. Requests presented while sel_ready=0 are not accepted and are not queued; the requester holds sel_valid until ready returns.
- FSM states: RUN, DRAIN, ARM.
- RUN:
  - clk_out <= taps[active_sel], i.e. one cycle of latency from the tap to the output.
  - On accept with sel >= NUM_TAPS: sel_err=1 for the next cycle only; state, active_sel and switch_cnt are unchanged.
  - On accept with sel == active_sel: no-op; stays in RUN, no count.
  - On accept with any other valid sel: pending <= sel; next state DRAIN.
- DRAIN:
  - clk_out <= taps[active_sel], so the current high phase completes.
  - When taps[active_sel] is sampled 0: active_sel <= pending; next state ARM.
  - Result: clk_out is never cut during a high phase.
- ARM:
  - clk_out <= 0.
  - When taps[active_sel] is sampled 0: next state RUN; switch_cnt <= switch_cnt + 1, except on the ARM exit that follows reset, which is not counted.
  - Result: clk_out stays low at least 1 cycle, and the new tap then starts on a clean rising edge.
- switch_cnt wrap: 2**CNT_W-1 wraps to 0 with no flag.
- Reset asserted in any state (including mid-DRAIN or mid-ARM): all outputs take their reset values immediately (asynchronous). The pending request is discarded.
- sel and sel_valid carry no reset requirement; they are sampled only when sel_ready=1.
- Taps are assumed synchronous to clk; no synchronizers are inside the block.

Test Plan:
- Reset release:
  - Stimulus: rst_n low 5 cycles, then high, with the divider running.
  - Required: clk_out=0 and busy=1 during reset. After release, ARM exits within 2 cycles. clk_out then equals taps[0] delayed by 1 cycle (period 2, high 1). active_sel=0, switch_cnt=0.
- Switch 0→3:
  - Stimulus: sel=3 with sel_valid for 1 cycle while in RUN.
  - Required: sel_ready=0 on the next cycle. No clk_out high or low phase is shorter than 1 cycle. clk_out settles to period 16, high 8. active_sel=3; switch_cnt=1; busy falls on the RUN entry.
- Down-switch 9→0:
  - Stimulus: sel=0 requested while taps[9] is high.
  - Required: clk_out stays high until taps[9] falls, so the full 512-cycle high phase completes. Then clk_out is low ≥1 cycle, then toggles every cycle.
- Invalid and same-tap requests:
  - Stimulus: sel=12 with valid, then sel=active_sel with valid.
  - Required: sel=12 gives sel_err high for exactly 1 cycle. In both cases active_sel, clk_out waveform and switch_cnt are unchanged, and sel_ready stays 1.
- Request during busy and counter wrap:
  - Stimulus: while in DRAIN, hold sel_valid with sel changing 5→7.
  - Required: no acceptance until RUN. Then sel=7 (the value at acceptance) takes effect.
  - Stimulus: preload switch_cnt to 255 via 255 switches, then one more switch.
  - Required: switch_cnt=0.
- Async reset mid-switch:
  - Stimulus: assert rst_n=0 two cycles into DRAIN (0→5).
  - Required: clk_out=0, active_sel=0, busy=1 in the same cycle, with no clk edge required. After release the block restarts from ARM on tap 0.
